// File: rtl/joy_serial_reader.sv
// rtl/joy_serial_reader.sv - JAMMA two-player serial joystick chain reader
module joy_serial_reader #(
    parameter int CLK_DIV  = 16,
    parameter bit DEBOUNCE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_done
);

    localparam logic [7:0] DIV_MAX   = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_SLOT = 5'd25;

    logic [7:0]  div;
    logic        jclk;
    logic [4:0]  slot;
    logic [1:0]  sync;
    logic [11:0] s1;
    logic [11:0] s2;
    logic [11:0] s1_next;
    logic [11:0] s2_next;
    logic [23:0] prev;
    logic        sample;
    logic        rise_tick;
    logic        frame_end;

    assign sample    = sync[1];
    assign rise_tick = (div == DIV_MAX) && !jclk;
    assign frame_end = rise_tick && (slot == LAST_SLOT);
    assign JOY_CLK   = jclk;

    // JOY_DATA comes from off-chip with no relation to clk; resynchronise it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], JOY_DATA};
        end
    end

    // Divider: jclk toggles every CLK_DIV clk cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= 8'd0;
            jclk <= 1'b0;
        end else if (div == DIV_MAX) begin
            div  <= 8'd0;
            jclk <= ~jclk;
        end else begin
            div  <= div + 8'd1;
        end
    end

    // Slot counter 0..25 and the load strobe, which is low exactly while slot is 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot     <= 5'd0;
            JOY_LOAD <= 1'b0;
        end else if (rise_tick) begin
            if (slot == LAST_SLOT) begin
                slot     <= 5'd0;
                JOY_LOAD <= 1'b0;
            end else begin
                slot     <= slot + 5'd1;
                JOY_LOAD <= 1'b1;
            end
        end
    end

    // Route the synchronised data bit into the shadow position owned by the current slot
    always_comb begin
        s1_next = s1;
        s2_next = s2;
        case (slot)
            5'd2:  s1_next[8]  = sample;
            5'd3:  s1_next[6]  = sample;
            5'd4:  s1_next[5]  = sample;
            5'd5:  s1_next[4]  = sample;
            5'd6:  s1_next[3]  = sample;
            5'd7:  s1_next[2]  = sample;
            5'd8:  s1_next[1]  = sample;
            5'd9:  s1_next[0]  = sample;
            5'd10: s2_next[8]  = sample;
            5'd11: s2_next[6]  = sample;
            5'd12: s2_next[5]  = sample;
            5'd13: s2_next[4]  = sample;
            5'd14: s2_next[3]  = sample;
            5'd15: s2_next[2]  = sample;
            5'd16: s2_next[1]  = sample;
            5'd17: s2_next[0]  = sample;
            5'd18: s2_next[10] = sample;
            5'd19: s2_next[11] = sample;
            5'd20: s2_next[9]  = sample;
            5'd21: s2_next[7]  = sample;
            5'd22: s1_next[10] = sample;
            5'd23: s1_next[11] = sample;
            5'd24: s1_next[9]  = sample;
            5'd25: s1_next[7]  = sample;
            default: ;
        endcase
    end

    // Shadow registers capture one bit per rise tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 12'hFFF;
            s2 <= 12'hFFF;
        end else if (rise_tick) begin
            s1 <= s1_next;
            s2 <= s2_next;
        end
    end

    // Frame commit; with debounce a frame must match its predecessor to be published
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= 24'hFFFFFF;
            joystick1  <= 12'hFFF;
            joystick2  <= 12'hFFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_end) begin
                prev <= {s1_next, s2_next};
                if (!DEBOUNCE || ({s1_next, s2_next} == prev)) begin
                    joystick1  <= s1_next;
                    joystick2  <= s2_next;
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule
